mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared backing memory between the instruction-cache miss path (read-only, I-port) and the data-cache miss/writeback path (read/write, D-port).
- Sits between the fetch/memory-stage caches and the multi-cycle main memory.
- Serialises one transaction at a time and registers the address, write data and response.
- Provides D-over-I priority with a starvation guard for I, plus a watchdog for memories that never complete.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations after which the I-port wins (range 1..15).
- TIMEOUT, 31: BUSY cycles without mem_done before the transaction is aborted (range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  I-port read request; held until i_done
- i_addr  in  16  I-port address
- i_done  out  1  one-cycle pulse; i_rdata valid this cycle
- i_rdata  out  16  registered read data
- i_stall  out  1  i_req & ~i_done
- d_req  in  1  D-port request; held until d_done
- d_wr  in  1  1 = write, 0 = read
- d_addr  in  16  D-port address
- d_wdata  in  16  D-port write data
- d_done  out  1  one-cycle pulse
- d_rdata  out  16  registered read data (0x0000 for writes)
- d_stall  out  1  d_req & ~d_done
- mem_rd  out  1  memory read strobe, held through BUSY
- mem_wr  out  1  memory write strobe, held through BUSY
- mem_addr  out  16  latched address
- mem_wdata  out  16  latched write data
- mem_rdata  in  16  memory read data, valid with mem_done
- mem_done  in  1  memory completion pulse
- err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY, RESP. A registered owner bit (0 = I, 1 = D) records the current transaction's port.
- Reset values: state = IDLE; owner = 0; all outputs, latches, starve counter and timeout counter = 0.
- IDLE:
  - If any request is present, latch addr, wdata and wr from the winner, set owner, clear the timeout counter, and go to BUSY.
  - If no request is present, stay in IDLE.
  - For the I-port, the latched wr is 0 and wdata is 0.
- Arbitration (IDLE only):
  - Only d_req: D wins.
  - Only i_req: I wins.
  - Both: D wins unless starve_cnt == STARVE_LIMIT, in which case I wins.
  - starve_cnt increments when both request and D wins. It clears whenever I is granted and saturates at STARVE_LIMIT.
- BUSY:
  - mem_rd = ~wr_latched and mem_wr = wr_latched, both held every cycle; mem_addr and mem_wdata come from the latches.
  - On mem_done: capture mem_rdata into the owner's rdata register (0x0000 if write) and go to RESP.
  - Otherwise, increment the timeout counter. On reaching TIMEOUT: set err, load rdata with 0x0000, and go to RESP.
- RESP:
  - The owner's done is 1 for exactly this cycle; strobes are 0.
  - The next state is always IDLE; no new grant happens in RESP.
  - The non-owner's rdata holds its previous value.
- Latency: request seen in IDLE at cycle t → strobes from t+1 → mem_done at cycle k → done at k+1 → IDLE at k+2. The minimum turnaround is 3 cycles.
- Requester contract: a requester deasserts req, or presents a new request, on the cycle after done. Req/addr changes while BUSY are ignored because the latches are used.
- mem_done outside BUSY is ignored.
- err is sticky until rst.
- rst asserted mid-transaction: outputs clear immediately (async), and the in-flight transaction is dropped with no done.
- i_stall and d_stall are combinational.

Test Plan:
- d_req=1, d_wr=0, d_addr=0x0040; mem_done with mem_rdata=0xBEEF 2 cycles after mem_rd rises → mem_addr=0x0040 and mem_rd=1 for 2 cycles, then d_done=1 for exactly 1 cycle with d_rdata=0xBEEF; i_done stays 0.
- d_req=1, d_wr=1, d_addr=0x0100, d_wdata=0x1234; mem_done on the first BUSY cycle → mem_wr=1 with mem_wdata=0x1234, d_done the next cycle, d_rdata=0x0000, back to IDLE 3 cycles after the request.
- i_req and d_req held high continuously, each re-requesting after its done, STARVE_LIMIT=4 → grant order is D,D,D,D,I,D,D,D,D,I.
- i_req=1, i_addr=0x0002, mem_done never asserted, TIMEOUT=31 → after 31 BUSY cycles i_done=1, i_rdata=0x0000, err=1 and it stays 1 across subsequent successful transactions until rst.
- rst pulsed during BUSY of a D write → mem_wr, d_done and err are 0 immediately; state is IDLE; a later i_req completes normally with no stale D response.
- d_addr changed from 0x0040 to 0x0080 during BUSY, plus a spurious mem_done while in IDLE → mem_addr stays 0x0040; the spurious mem_done causes no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between the I-cache read path and the D-cache read/write path.
// One transaction at a time; D has priority, and a starvation counter eventually lets I through.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_rdata,
   output logic        i_stall,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        d_stall,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_done,
   output logic        err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [7:0] TMO_MAX    = 8'(TIMEOUT);

   // Handshake: a requester holds req (and its address/data) until it sees its done pulse,
   // then drops or re-presents req on the following cycle; the arbiter latches on grant.
   state_t      state, next_state;
   logic        owner;
   logic        wr_lat;
   logic [15:0] addr_lat;
   logic [15:0] wdata_lat;
   logic [3:0]  starve_cnt;
   logic [7:0]  tmo_cnt;
   logic [7:0]  tmo_next;
   logic        any_req;
   logic        grant_d;
   logic        timeout_hit;

   assign any_req     = i_req | d_req;
   assign grant_d     = d_req & (~i_req | (starve_cnt != STARVE_MAX));
   assign tmo_next    = tmo_cnt + 8'd1;
   assign timeout_hit = ~mem_done & (tmo_next == TMO_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (any_req) next_state = BUSY;
         BUSY:    if (mem_done || timeout_hit) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner      <= 1'b0;
         wr_lat     <= 1'b0;
         addr_lat   <= 16'h0000;
         wdata_lat  <= 16'h0000;
         starve_cnt <= 4'd0;
         tmo_cnt    <= 8'd0;
         err        <= 1'b0;
         i_rdata    <= 16'h0000;
         d_rdata    <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= grant_d;
                  wr_lat    <= grant_d & d_wr;
                  addr_lat  <= grant_d ? d_addr : i_addr;
                  wdata_lat <= grant_d ? d_wdata : 16'h0000;
                  tmo_cnt   <= 8'd0;
                  // Only a contested win by D counts toward starving I.
                  if (!grant_d)
                     starve_cnt <= 4'd0;
                  else if (i_req && starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            BUSY: begin
               if (mem_done) begin
                  if (owner) d_rdata <= wr_lat ? 16'h0000 : mem_rdata;
                  else       i_rdata <= mem_rdata;
               end else begin
                  tmo_cnt <= tmo_next;
                  if (timeout_hit) begin
                     err <= 1'b1;
                     if (owner) d_rdata <= 16'h0000;
                     else       i_rdata <= 16'h0000;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_rd    = (state == BUSY) & ~wr_lat;
   assign mem_wr    = (state == BUSY) & wr_lat;
   assign mem_addr  = addr_lat;
   assign mem_wdata = wdata_lat;
   assign i_done    = (state == RESP) & ~owner;
   assign d_done    = (state == RESP) & owner;
   assign i_stall   = i_req & ~i_done;
   assign d_stall   = d_req & ~d_done;
   assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a vector table of single transactions plus
// hand-written sequences for starvation, timeout, mid-transaction reset and ignored inputs.
module tb_mem_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = 16'h0000;
   logic        i_done;
   logic [15:0] i_rdata;
   logic        i_stall;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] d_wdata = 16'h0000;
   logic        d_done;
   logic [15:0] d_rdata;
   logic        d_stall;
   logic        mem_rd;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = 16'h0000;
   logic        mem_done = 1'b0;
   logic        err;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .err(err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        i_req;
      logic        d_req;
      logic        d_wr;
      logic [15:0] i_addr;
      logic [15:0] d_addr;
      logic [15:0] d_wdata;
      int          lat;
      logic [15:0] mem_rdata;
      logic        exp_d;
      logic        exp_wr;
      logic [15:0] exp_addr;
      logic [15:0] exp_wdata;
      logic [15:0] exp_rdata;
      logic [15:0] exp_other;
   } vec_t;

   vec_t vecs[5];

   // One complete transaction; lat = number of BUSY cycles before the mem_done cycle.
   task automatic run_vec(input vec_t v, input logic exp_err);
      @(negedge clk);
      i_req = v.i_req; d_req = v.d_req; d_wr = v.d_wr;
      i_addr = v.i_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
      @(negedge clk);
      check("busy_state", 32'(dbg_state), 32'(S_BUSY));
      check("mem_addr", 32'(mem_addr), 32'(v.exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(v.exp_wdata));
      for (int b = 0; b <= v.lat; b++) begin
         check("busy_strobes", 32'({mem_rd, mem_wr}), 32'({~v.exp_wr, v.exp_wr}));
         check("busy_no_done", 32'({i_done, d_done}), 32'd0);
         if (b == v.lat) begin
            mem_done = 1'b1;
            mem_rdata = v.mem_rdata;
         end
         @(negedge clk);
      end
      mem_done = 1'b0;
      check("resp_state", 32'(dbg_state), 32'(S_RESP));
      check("resp_done", 32'({i_done, d_done}), 32'({~v.exp_d, v.exp_d}));
      check("resp_rdata", 32'(v.exp_d ? d_rdata : i_rdata), 32'(v.exp_rdata));
      check("resp_other_rdata", 32'(v.exp_d ? i_rdata : d_rdata), 32'(v.exp_other));
      check("resp_strobes", 32'({mem_rd, mem_wr}), 32'd0);
      check("resp_stalls", 32'({i_stall, d_stall}),
            32'({v.i_req & v.exp_d, v.d_req & ~v.exp_d}));
      check("resp_err", 32'(err), 32'(exp_err));
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      check("back_idle", 32'(dbg_state), 32'(S_IDLE));
      check("idle_no_done", 32'({i_done, d_done}), 32'd0);
   endtask

   logic exp_grant[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   vec_t v_tmp;
   int   cnt;

   initial begin
      //        i  d  wr i_addr    d_addr    d_wdata  lat rdata     D  wr exp_addr  exp_wd    exp_rd    other
      vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, 16'h0000, 1, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0100, 16'h1234, 0, 16'h5555, 1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000, 16'h0000};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'h9999, 2, 16'hCAFE, 1'b0, 1'b0, 16'h0200, 16'h0000, 16'hCAFE, 16'h0000};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0A00, 16'h0300, 16'h0000, 0, 16'h1111, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h1111, 16'hCAFE};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0000, 3, 16'h2222, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'h2222, 16'h1111};

      repeat (2) @(negedge clk);
      check("reset_state", 32'(dbg_state), 32'(S_IDLE));
      check("reset_outputs", 32'({i_done, d_done, mem_rd, mem_wr, err}), 32'd0);
      check("reset_data", 32'({i_rdata, d_rdata}), 32'd0);
      check("reset_mem_bus", 32'({mem_addr, mem_wdata}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_no_req", 32'(dbg_state), 32'(S_IDLE));

      for (int n = 0; n < 5; n++) run_vec(vecs[n], 1'b0);

      // Both ports request back to back; the starve counter starts from 0 (last grant was I).
      @(negedge clk);
      i_req = 1'b1; d_req = 1'b1; d_wr = 1'b0; i_addr = 16'h0C00; d_addr = 16'h0D00;
      for (int n = 0; n < 10; n++) begin
         cnt = 0;
         while (dbg_state != S_BUSY && cnt < 5) begin
            @(negedge clk);
            cnt++;
         end
         check("starve_wait_busy", 32'(dbg_state), 32'(S_BUSY));
         mem_done = 1'b1; mem_rdata = 16'(n);
         @(negedge clk);
         mem_done = 1'b0;
         check("starve_grant", 32'({i_done, d_done}), 32'({~exp_grant[n], exp_grant[n]}));
      end
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);

      // Memory never answers: watchdog aborts after TIMEOUT BUSY cycles.
      i_req = 1'b1; i_addr = 16'h0002;
      @(negedge clk);
      cnt = 0;
      while (dbg_state == S_BUSY && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      check("timeout_busy_cycles", 32'(cnt), 32'd31);
      check("timeout_i_done", 32'(i_done), 32'd1);
      check("timeout_rdata", 32'(i_rdata), 32'h0000);
      check("timeout_err", 32'(err), 32'd1);
      i_req = 1'b0;
      @(negedge clk);
      v_tmp = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0700, 16'h0000, 0, 16'h3333, 1'b1, 1'b0, 16'h0700, 16'h0000, 16'h3333, 16'h0000};
      run_vec(v_tmp, 1'b1);

      // Reset lands in the middle of a D write.
      @(negedge clk);
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0500; d_wdata = 16'hAAAA;
      @(negedge clk);
      check("pre_reset_wr", 32'(mem_wr), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("reset_mid_outputs", 32'({mem_wr, mem_rd, d_done, err}), 32'd0);
      check("reset_mid_state", 32'(dbg_state), 32'(S_IDLE));
      d_req = 1'b0; d_wr = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_idle", 32'({dbg_state, i_done, d_done}), 32'd0);
      v_tmp = '{1'b1, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h0000, 1, 16'h7777, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h7777, 16'h0000};
      run_vec(v_tmp, 1'b0);

      // Address change during BUSY and a stray mem_done in IDLE are both ignored.
      @(negedge clk);
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
      @(negedge clk);
      d_addr = 16'h0080;
      @(negedge clk);
      check("addr_held", 32'(mem_addr), 32'h0040);
      mem_done = 1'b1; mem_rdata = 16'h4321;
      @(negedge clk);
      mem_done = 1'b0;
      check("addr_chg_done", 32'({i_done, d_done}), 32'b01);
      check("addr_chg_rdata", 32'(d_rdata), 32'h4321);
      d_req = 1'b0;
      @(negedge clk);
      mem_done = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      mem_done = 1'b0;
      check("spurious_no_done", 32'({i_done, d_done, mem_rd, mem_wr}), 32'd0);
      check("spurious_state", 32'(dbg_state), 32'(S_IDLE));
      @(negedge clk);
      check("spurious_rdata", 32'(d_rdata), 32'h4321);
      check("spurious_still_idle", 32'({dbg_state, i_done, d_done}), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
